// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/loader arbiter and sequencer for data_memory.
// Optional loader burst lock is built when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [2:0]       cpu_mode,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic             cpu_err,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             ldr_req,
    input  logic             ldr_we,
    input  logic [2:0]       ldr_mode,
    input  logic [WIDTH-1:0] ldr_addr,
    input  logic [WIDTH-1:0] ldr_wdata,
    output logic             ldr_ack,
    output logic             ldr_err,
    output logic [WIDTH-1:0] ldr_rdata,
    input  logic             ldr_lock,
    output logic [2:0]       mem_mode,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic             cpu_ack_q, cpu_ack_d;
    logic             cpu_err_q, cpu_err_d;
    logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic             ldr_ack_q, ldr_ack_d;
    logic             ldr_err_q, ldr_err_d;
    logic [WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;
    logic             last_q, last_d;

    logic cpu_elig, ldr_elig;
    logic grant_cpu, grant_ldr;
    logic cpu_excl, force_clr;
    logic sel_we, sel_ok;

    function automatic logic legal(input logic [2:0] mode,
                                   input logic [1:0] lsb);
        legal = 1'b0;
        unique case (1'b1)
            (mode == 3'b001):                   legal = (lsb == 2'b00);
            (mode == 3'b010), (mode == 3'b100): legal = ~lsb[0];
            (mode == 3'b011), (mode == 3'b101): legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    endfunction

    // An ack in flight blocks that port for one cycle of turnaround
    assign cpu_elig  = cpu_req & ~cpu_ack_q & ~cpu_excl;
    assign ldr_elig  = ldr_req & ~ldr_ack_q;
    assign grant_cpu = cpu_elig & (~ldr_elig | last_q);
    assign grant_ldr = ldr_elig & ~grant_cpu;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          lock_q, lock_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        lock_d    = lock_q;
        cnt_d     = '0;
        force_clr = 1'b0;
        if (lock_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(LOCK_MAX)) begin
                force_clr = 1'b1;
                lock_d    = 1'b0;
                cnt_d     = '0;
            end else if (!ldr_lock) begin
                lock_d = 1'b0;
                cnt_d  = '0;
            end
        end else begin
            lock_d = grant_ldr & ldr_lock;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cpu_excl = lock_q;
`else
    logic unused_lock;
    assign unused_lock = ldr_lock;
    assign cpu_excl    = 1'b0;
    assign force_clr   = 1'b0;
`endif

    always_comb begin
        mem_mode  = cpu_mode;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        sel_we    = cpu_we;
        if (grant_ldr) begin
            mem_mode  = ldr_mode;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
            sel_we    = ldr_we;
        end
        sel_ok = legal(mem_mode, mem_addr[1:0]);
        mem_we = (grant_cpu | grant_ldr) & sel_ok & sel_we & ~rst;
    end

    always_comb begin
        cpu_ack_d   = grant_cpu;
        cpu_err_d   = grant_cpu & ~sel_ok;
        cpu_rdata_d = cpu_rdata_q;
        ldr_ack_d   = grant_ldr;
        ldr_err_d   = grant_ldr & ~sel_ok;
        ldr_rdata_d = ldr_rdata_q;
        last_d      = last_q;
        if (grant_cpu) begin
            cpu_rdata_d = sel_ok ? mem_rdata : '0;
            last_d      = 1'b0;
        end
        if (grant_ldr) begin
            ldr_rdata_d = sel_ok ? mem_rdata : '0;
            last_d      = 1'b1;
        end
        // A lock that timed out hands the next tie to the CPU
        if (force_clr) last_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_ack_q   <= 1'b0;
            ldr_err_q   <= 1'b0;
            ldr_rdata_q <= '0;
            last_q      <= 1'b1;
        end else begin
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_ack_q   <= ldr_ack_d;
            ldr_err_q   <= ldr_err_d;
            ldr_rdata_q <= ldr_rdata_d;
            last_q      <= last_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_ack   = ldr_ack_q;
    assign ldr_err   = ldr_err_q;
    assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter with a byte memory and a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int W   = 32;
    localparam int LM  = 16;
    localparam int MSZ = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         cpu_req, cpu_we, cpu_ack, cpu_err;
    logic [2:0]   cpu_mode;
    logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic         ldr_req, ldr_we, ldr_ack, ldr_err, ldr_lock;
    logic [2:0]   ldr_mode;
    logic [W-1:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic [2:0]   mem_mode;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_we;

    dmem_arbiter #(.WIDTH(W), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_mode(ldr_mode),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_err(ldr_err), .ldr_rdata(ldr_rdata),
        .ldr_lock(ldr_lock),
        .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] dmem [MSZ];
    logic [7:0] rmem [MSZ];
    logic       mem_init;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16: return 8'hEF;
            17: return 8'hBE;
            18: return 8'hAD;
            19: return 8'hDE;
            default: return 8'((i * 37 + 11) ^ (i >> 3));
        endcase
    endfunction

    function automatic int ix(input logic [W-1:0] a, input int k);
        logic [8:0] t;
        t = a[8:0] + 9'(k);
        return int'(t);
    endfunction

    function automatic logic [W-1:0] fmt(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [2:0] mode);
        case (mode)
            3'b001:  return {b3, b2, b1, b0};
            3'b010:  return {{16{b1[7]}}, b1, b0};
            3'b011:  return {{24{b0[7]}}, b0};
            3'b100:  return {16'h0, b1, b0};
            3'b101:  return {24'h0, b0};
            default: return '0;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] mode, input logic [W-1:0] a);
        int ai;
        ai = int'(a[7:0]);
        case (mode)
            3'd1:       return (ai % 4) == 0;
            3'd2, 3'd4: return (ai % 2) == 0;
            3'd3, 3'd5: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // Memory the DUT talks to: combinational read, write at the edge
    assign mem_rdata = fmt(dmem[ix(mem_addr, 0)], dmem[ix(mem_addr, 1)],
                           dmem[ix(mem_addr, 2)], dmem[ix(mem_addr, 3)], mem_mode);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MSZ; i++) dmem[i] <= init_byte(i);
        end else if (mem_we) begin
            dmem[ix(mem_addr, 0)] <= mem_wdata[7:0];
            if (mem_mode == 3'd1 || mem_mode == 3'd2 || mem_mode == 3'd4)
                dmem[ix(mem_addr, 1)] <= mem_wdata[15:8];
            if (mem_mode == 3'd1) begin
                dmem[ix(mem_addr, 2)] <= mem_wdata[23:16];
                dmem[ix(mem_addr, 3)] <= mem_wdata[31:24];
            end
        end
    end

    bit           e_last, e_lock, e_cpu_ack, e_ldr_ack, e_cpu_err, e_ldr_err;
    int           e_cnt;
    logic [W-1:0] e_cpu_rdata, e_ldr_rdata;

    task automatic model_reset();
        e_last = 1; e_lock = 0; e_cnt = 0;
        e_cpu_ack = 0; e_ldr_ack = 0; e_cpu_err = 0; e_ldr_err = 0;
        e_cpu_rdata = '0; e_ldr_rdata = '0;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_mode = 3'd1; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_mode = 3'd1; ldr_addr = '0; ldr_wdata = '0;
        ldr_lock = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        mem_init = 0;
        rst = 0;
        model_reset();
    endtask

    // One cycle: predict grant, check memory side, advance model, check responses
    task automatic tick(output bit gc, output bit gl, output logic we_obs);
        bit           cel, lel, ok, wwe, expwe, forced;
        logic [W-1:0] wa, wd, rd;
        logic [2:0]   wm;
        #1;
        cel = cpu_req && !e_cpu_ack && !e_lock;
        lel = ldr_req && !e_ldr_ack;
        if (cel && lel) begin
            gc = e_last;
            gl = !e_last;
        end else begin
            gc = cel;
            gl = lel;
        end
        wa = gl ? ldr_addr : cpu_addr;
        wd = gl ? ldr_wdata : cpu_wdata;
        wm = gl ? ldr_mode : cpu_mode;
        wwe = gl ? ldr_we : cpu_we;
        ok = legal(wm, wa);
        expwe = (gc || gl) && ok && wwe;
        we_obs = mem_we;
        checks++;
        if (mem_we !== expwe) begin
            errors++;
            $display("FAIL mem_we t=%0t got %b exp %b", $time, mem_we, expwe);
        end
        if (gc || gl) begin
            checks++;
            if (mem_addr !== wa || mem_wdata !== wd || mem_mode !== wm) begin
                errors++;
                $display("FAIL mem_bus t=%0t got %h/%h/%0d exp %h/%h/%0d",
                         $time, mem_addr, mem_wdata, mem_mode, wa, wd, wm);
            end
        end
        rd = ok ? fmt(rmem[ix(wa, 0)], rmem[ix(wa, 1)], rmem[ix(wa, 2)],
                      rmem[ix(wa, 3)], wm) : '0;
        if (expwe) begin
            rmem[ix(wa, 0)] = wd[7:0];
            if (wm == 3'd1 || wm == 3'd2 || wm == 3'd4) rmem[ix(wa, 1)] = wd[15:8];
            if (wm == 3'd1) begin
                rmem[ix(wa, 2)] = wd[23:16];
                rmem[ix(wa, 3)] = wd[31:24];
            end
        end
        forced = 0;
`ifdef DMEM_ARB_LOCK_EN
        if (e_lock) begin
            e_cnt++;
            if (e_cnt == LM) begin
                e_lock = 0; e_cnt = 0; forced = 1;
            end else if (!ldr_lock) begin
                e_lock = 0; e_cnt = 0;
            end
        end else if (gl && ldr_lock) begin
            e_lock = 1;
        end
`endif
        if (gc) e_last = 0;
        if (gl) e_last = 1;
        if (forced) e_last = 1;
        e_cpu_ack = gc;
        e_ldr_ack = gl;
        if (gc) begin e_cpu_err = !ok; e_cpu_rdata = rd; end
        if (gl) begin e_ldr_err = !ok; e_ldr_rdata = rd; end
        @(posedge clk);
        #1;
        checks++;
        if (cpu_ack !== e_cpu_ack || ldr_ack !== e_ldr_ack) begin
            errors++;
            $display("FAIL acks t=%0t got %b%b exp %b%b",
                     $time, cpu_ack, ldr_ack, e_cpu_ack, e_ldr_ack);
        end
        checks++;
        if ((e_cpu_ack && cpu_err !== e_cpu_err) || (e_ldr_ack && ldr_err !== e_ldr_err)) begin
            errors++;
            $display("FAIL errs t=%0t got %b%b exp %b%b",
                     $time, cpu_err, ldr_err, e_cpu_err, e_ldr_err);
        end
        checks++;
        if (cpu_rdata !== e_cpu_rdata || ldr_rdata !== e_ldr_rdata) begin
            errors++;
            $display("FAIL rdata t=%0t got %h/%h exp %h/%h",
                     $time, cpu_rdata, ldr_rdata, e_cpu_rdata, e_ldr_rdata);
        end
    endtask

    task automatic new_txn(output logic we, output logic [2:0] mode,
                           output logic [W-1:0] addr, output logic [W-1:0] wd);
        int r;
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 85) begin
            mode = 3'($urandom_range(1, 5));
        end else begin
            r = $urandom_range(0, 2);
            mode = (r == 0) ? 3'd0 : (r == 1) ? 3'd6 : 3'd7;
        end
        addr = W'($urandom_range(0, MSZ - 1));
        if ($urandom_range(0, 9) < 8) begin
            if (mode == 3'd1) addr[1:0] = 2'b00;
            else if (mode == 3'd2 || mode == 3'd4) addr[0] = 1'b0;
        end
        wd = $urandom;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cpu_ack !== 0 || ldr_ack !== 0 || cpu_err !== 0 || ldr_err !== 0 ||
            cpu_rdata !== '0 || ldr_rdata !== '0 || mem_we !== 0) begin
            errors++;
            $display("FAIL reset_state got ack %b%b err %b%b rd %h/%h we %b exp zeros",
                     cpu_ack, ldr_ack, cpu_err, ldr_err, cpu_rdata, ldr_rdata, mem_we);
        end
    endtask

    task automatic test_load_word();
        bit gc, gl;
        logic wo;
        cpu_req = 1; cpu_we = 0; cpu_mode = 3'd1; cpu_addr = 32'h10;
        tick(gc, gl, wo);
        cpu_req = 0;
        checks++;
        if (cpu_ack !== 1 || cpu_err !== 0 || cpu_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_word got ack %b err %b rd %h exp 1 0 deadbeef",
                     cpu_ack, cpu_err, cpu_rdata);
        end
        tick(gc, gl, wo);
        checks++;
        if (cpu_ack !== 0 || cpu_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_word_pulse got ack %b rd %h exp 0 deadbeef", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_alternate();
        bit gc, gl;
        logic wo;
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_mode = 3'd1; cpu_addr = 32'h80; cpu_wdata = $urandom;
        ldr_req = 1; ldr_we = 1; ldr_mode = 3'd1; ldr_addr = 32'hC0; ldr_wdata = $urandom;
        for (int n = 0; n < 12; n++) begin
            tick(gc, gl, wo);
            checks++;
            if (cpu_ack !== 1'(n % 2 == 0) || ldr_ack !== 1'(n % 2 == 1)) begin
                errors++;
                $display("FAIL alternate n=%0d got %b%b exp %b%b",
                         n, cpu_ack, ldr_ack, 1'(n % 2 == 0), 1'(n % 2 == 1));
            end
            if (cpu_ack) begin cpu_addr = cpu_addr + 4; cpu_wdata = $urandom; end
            if (ldr_ack) begin ldr_addr = ldr_addr + 4; ldr_wdata = $urandom; end
        end
        idle_inputs();
        tick(gc, gl, wo);
    endtask

    task automatic test_illegal();
        bit gc, gl;
        logic wo;
        logic [2:0]   modes [3];
        logic [W-1:0] addrs [3];
        modes[0] = 3'd1; addrs[0] = 32'h12;
        modes[1] = 3'd0; addrs[1] = 32'h20;
        modes[2] = 3'd7; addrs[2] = 32'h24;
        for (int k = 0; k < 3; k++) begin
            cpu_req = 1; cpu_we = 1; cpu_mode = modes[k]; cpu_addr = addrs[k];
            cpu_wdata = 32'hA5A5_5A5A;
            tick(gc, gl, wo);
            cpu_req = 0;
            checks++;
            if (wo !== 0 || cpu_ack !== 1 || cpu_err !== 1 || cpu_rdata !== '0) begin
                errors++;
                $display("FAIL illegal k=%0d got we %b ack %b err %b rd %h exp 0 1 1 0",
                         k, wo, cpu_ack, cpu_err, cpu_rdata);
            end
            checks++;
            if (dmem[ix(addrs[k], 0)] !== init_byte(ix(addrs[k], 0)) ||
                dmem[ix(addrs[k], 1)] !== init_byte(ix(addrs[k], 1))) begin
                errors++;
                $display("FAIL illegal_mem k=%0d got %h%h exp %h%h", k,
                         dmem[ix(addrs[k], 1)], dmem[ix(addrs[k], 0)],
                         init_byte(ix(addrs[k], 1)), init_byte(ix(addrs[k], 0)));
            end
            tick(gc, gl, wo);
        end
    endtask

    task automatic test_lock();
        bit gc, gl;
        logic wo;
        int waited;
        int want;
        do_reset();
        ldr_req = 1; ldr_lock = 1; ldr_we = 1; ldr_mode = 3'd1;
        ldr_addr = 32'h180; ldr_wdata = $urandom;
        tick(gc, gl, wo);
        cpu_req = 1; cpu_we = 0; cpu_mode = 3'd1; cpu_addr = 32'h1A0;
        waited = -1;
        for (int i = 0; i < 40 && waited < 0; i++) begin
            if (ldr_ack) begin ldr_addr = ldr_addr + 4; ldr_wdata = $urandom; end
            tick(gc, gl, wo);
            if (cpu_ack === 1) waited = i;
        end
        cpu_req = 0;
`ifdef DMEM_ARB_LOCK_EN
        want = LM;
`else
        want = 0;
`endif
        checks++;
        if (waited != want) begin
            errors++;
            $display("FAIL lock_wait got %0d cycles exp %0d", waited, want);
        end
        idle_inputs();
        repeat (3) tick(gc, gl, wo);
    endtask

    task automatic test_rst_grant();
        do_reset();
        ldr_req = 1; ldr_we = 1; ldr_mode = 3'd3; ldr_addr = 32'h40;
        ldr_wdata = {24'h0, ~rmem[32'h40]};
        #1;
        rst = 1;
        #1;
        checks++;
        if (mem_we !== 0) begin
            errors++;
            $display("FAIL rst_we got %b exp 0", mem_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ldr_ack !== 0 || cpu_ack !== 0 || ldr_err !== 0 || cpu_err !== 0 ||
            ldr_rdata !== '0 || cpu_rdata !== '0) begin
            errors++;
            $display("FAIL rst_outputs got ack %b%b err %b%b rd %h/%h exp zeros",
                     cpu_ack, ldr_ack, cpu_err, ldr_err, cpu_rdata, ldr_rdata);
        end
        checks++;
        if (dmem[32'h40] !== rmem[32'h40]) begin
            errors++;
            $display("FAIL rst_mem got %h exp %h", dmem[32'h40], rmem[32'h40]);
        end
        idle_inputs();
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        bit gc, gl;
        logic wo;
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    cpu_req = 1;
                    new_txn(cpu_we, cpu_mode, cpu_addr, cpu_wdata);
                end
            end else if ($urandom_range(0, 49) == 0) begin
                cpu_req = 0;
            end
            if (!ldr_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    ldr_req = 1;
                    ldr_lock = ($urandom_range(0, 3) == 0);
                    new_txn(ldr_we, ldr_mode, ldr_addr, ldr_wdata);
                end
            end else if ($urandom_range(0, 49) == 0) begin
                ldr_req = 0;
            end
            tick(gc, gl, wo);
            if (gc) cpu_req = 0;
            if (gl) ldr_req = 0;
        end
        idle_inputs();
        repeat (2) tick(gc, gl, wo);
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < MSZ; i++) if (dmem[i] !== rmem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_image got %0d differing bytes exp 0", bad);
        end
    endtask

    initial begin
        mem_init = 1;
        for (int i = 0; i < MSZ; i++) rmem[i] = init_byte(i);
        test_reset();
        test_load_word();
        test_alternate();
        test_illegal();
        test_lock();
        test_rst_grant();
        test_random();
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
